vio_stim_sequencer: RTL and testbench

VIO_STIM_SEQUENCER -- requirements
Module: vio_stim_sequencer

---
 rtl/vio_stim_sequencer_if.sv | 38 +++
 rtl/vio_stim_sequencer.sv | 139 +++++++++++++
 tb/tb_vio_stim_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vio_stim_sequencer_if.sv
// Bus bundle between the stimulus sequencer and whoever owns the VIO/step-memory side.
// The sequencer takes the slave modport; the environment driving it takes master.
interface vio_stim_sequencer_if #(
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]          vio_btn;
    logic [15:0]         vio_sw;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [21+HOLD_W-1:0] wr_data;
    logic [4:0]          num_steps;
    logic                start;
    logic                abort;
    logic                loop;
    logic [15:0]         led_in;
    logic [4:0]          btn_out;
    logic [15:0]         sw_out;
    logic                busy;
    logic [AW-1:0]       step_idx;
    logic                step_done;
    logic [15:0]         cap_led;
    logic                done;

    modport master (
        output vio_btn, vio_sw, wr_en, wr_addr, wr_data, num_steps,
               start, abort, loop, led_in,
        input  btn_out, sw_out, busy, step_idx, step_done, cap_led, done
    );

    modport slave (
        input  vio_btn, vio_sw, wr_en, wr_addr, wr_data, num_steps,
               start, abort, loop, led_in,
        output btn_out, sw_out, busy, step_idx, step_done, cap_led, done
    );
endinterface

// File: rtl/vio_stim_sequencer.sv
// Replays a small table of {buttons, switches, hold} steps onto a DUT, capturing its LEDs
// at the end of each step; hands the buttons/switches back to the VIO whenever idle.
module vio_stim_sequencer #(
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    vio_stim_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 21 + HOLD_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [4:0]        btn_out_q, btn_out_d;
    logic [15:0]       sw_out_q, sw_out_d;
    logic [15:0]       cap_led_q, cap_led_d;
    logic [AW-1:0]     step_idx_q, step_idx_d;
    logic              step_done_q, step_done_d;
    logic              done_q, done_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [4:0]        n_q, n_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic [4:0]        n_eff;
    logic              last_step;
    logic              load;
    logic [AW-1:0]     load_idx;
    logic [EW-1:0]     ent;

    function automatic logic [4:0] ent_btn(input logic [EW-1:0] e);
        return e[EW-1 -: 5];
    endfunction

    function automatic logic [15:0] ent_sw(input logic [EW-1:0] e);
        return e[HOLD_W +: 16];
    endfunction

    function automatic logic [HOLD_W-1:0] ent_hold(input logic [EW-1:0] e);
        return e[HOLD_W-1:0];
    endfunction

    // Step table is deliberately left unreset; it is only writable while idle.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state_q == IDLE) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        n_eff       = (bus.num_steps > 5'(DEPTH)) ? 5'(DEPTH) : bus.num_steps;
        last_step   = (5'(step_idx_q) + 5'd1) == n_q;
        state_d     = state_q;
        btn_out_d   = bus.vio_btn;
        sw_out_d    = bus.vio_sw;
        cap_led_d   = cap_led_q;
        step_idx_d  = '0;
        step_done_d = 1'b0;
        done_d      = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        n_d         = n_q;
        load        = 1'b0;
        load_idx    = '0;

        if (state_q == IDLE) begin
            if (bus.start && !bus.abort && n_eff != 5'd0) begin
                state_d = RUN;
                n_d     = n_eff;
                load    = 1'b1;
            end
        end else begin
            if (bus.abort) begin
                state_d = IDLE;
            end else if (hold_cnt_q != '0) begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                step_idx_d = step_idx_q;
                btn_out_d  = btn_out_q;
                sw_out_d   = sw_out_q;
            end else begin
                // Last cycle of the step: capture, then chain straight into the next step.
                cap_led_d   = bus.led_in;
                step_done_d = 1'b1;
                if (!last_step) begin
                    load     = 1'b1;
                    load_idx = step_idx_q + AW'(1);
                end else begin
                    done_d = 1'b1;
                    if (bus.loop) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        end

        ent = mem_q[load_idx];
        if (load) begin
            step_idx_d = load_idx;
            btn_out_d  = ent_btn(ent);
            sw_out_d   = ent_sw(ent);
            hold_cnt_d = ent_hold(ent);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            btn_out_q   <= '0;
            sw_out_q    <= '0;
            cap_led_q   <= '0;
            step_idx_q  <= '0;
            step_done_q <= 1'b0;
            done_q      <= 1'b0;
            hold_cnt_q  <= '0;
            n_q         <= '0;
        end else begin
            state_q     <= state_d;
            btn_out_q   <= btn_out_d;
            sw_out_q    <= sw_out_d;
            cap_led_q   <= cap_led_d;
            step_idx_q  <= step_idx_d;
            step_done_q <= step_done_d;
            done_q      <= done_d;
            hold_cnt_q  <= hold_cnt_d;
            n_q         <= n_d;
        end
    end

    assign bus.btn_out   = btn_out_q;
    assign bus.sw_out    = sw_out_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.step_idx  = step_idx_q;
    assign bus.step_done = step_done_q;
    assign bus.cap_led   = cap_led_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_vio_stim_sequencer.sv
// Bench for vio_stim_sequencer: expected per-cycle output trace built from the step table,
// compared every cycle, plus literal spot checks on manual mode, capture, loop, abort and reset.
module tb_vio_stim_sequencer;
    localparam int DEPTH  = 16;
    localparam int HOLD_W = 16;

    logic clk = 1'b0;
    logic rst;

    vio_stim_sequencer_if #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus();

    vio_stim_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         man;
        logic [4:0] btn;
        logic [15:0] sw;
        int         idx;
        bit         busy;
        bit         sd;
        bit         dn;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  mem_btn  [DEPTH];
    logic [15:0] mem_sw   [DEPTH];
    logic [15:0] mem_hold [DEPTH];

    int total = 0;
    int bad   = 0;
    int sd_cnt = 0;
    int dn_cnt = 0;
    int sd0, dn0;
    bit chk_en = 1'b0;

    logic [4:0]  sb_btn;
    logic [15:0] sb_sw;
    logic [15:0] sb_led;
    logic [15:0] cap_exp = '0;
    exp_t        e_cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Expected trace of one run: each step shows for hold+1 cycles, pulses land on the
    // first cycle of the following step, and the run closes with a manual done cycle.
    task automatic push_run(input int n, input int passes, input int limit);
        int   cnt;
        exp_t e;
        cnt = 0;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < n; k++) begin
                for (int c = 0; c <= int'(mem_hold[k]); c++) begin
                    if (cnt == limit) return;
                    e.man  = 1'b0;
                    e.btn  = mem_btn[k];
                    e.sw   = mem_sw[k];
                    e.idx  = k;
                    e.busy = 1'b1;
                    e.sd   = (c == 0) && (k > 0 || p > 0);
                    e.dn   = (c == 0) && (k == 0) && (p > 0);
                    exp_q.push_back(e);
                    cnt++;
                end
            end
        end
        e.man = 1'b1; e.btn = '0; e.sw = '0; e.idx = 0;
        e.busy = 1'b0; e.sd = 1'b1; e.dn = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wr_mem(input int a, input logic [4:0] b, input logic [15:0] s,
                          input logic [15:0] h);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = {b, s, h};
        @(negedge clk);
        bus.wr_en = 1'b0;
        mem_btn[a]  = b;
        mem_sw[a]   = s;
        mem_hold[a] = h;
    endtask

    task automatic drain(input int limit);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Per-cycle scoreboard; an empty trace means the block must be idle and manual.
    always @(posedge clk) begin
        sb_btn = bus.vio_btn;
        sb_sw  = bus.vio_sw;
        sb_led = bus.led_in;
        #1;
        if (rst) begin
            cap_exp = '0;
        end else if (chk_en) begin
            if (exp_q.size() > 0) begin
                e_cur = exp_q.pop_front();
            end else begin
                e_cur.man = 1'b1; e_cur.btn = '0; e_cur.sw = '0; e_cur.idx = 0;
                e_cur.busy = 1'b0; e_cur.sd = 1'b0; e_cur.dn = 1'b0;
            end
            if (e_cur.sd) cap_exp = sb_led;
            chk("btn_out",   32'(bus.btn_out),   32'(e_cur.man ? sb_btn : e_cur.btn));
            chk("sw_out",    32'(bus.sw_out),    32'(e_cur.man ? sb_sw : e_cur.sw));
            chk("busy",      32'(bus.busy),      32'(e_cur.busy));
            chk("step_idx",  32'(bus.step_idx),  32'(e_cur.idx));
            chk("step_done", 32'(bus.step_done), 32'(e_cur.sd));
            chk("done",      32'(bus.done),      32'(e_cur.dn));
            chk("cap_led",   32'(bus.cap_led),   32'(cap_exp));
            if (bus.step_done === 1'b1) sd_cnt++;
            if (bus.done === 1'b1) dn_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.vio_btn = '0; bus.vio_sw = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.num_steps = '0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.loop = 1'b0; bus.led_in = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_btn",  32'(bus.btn_out),   32'd0);
        chk("rst_sw",   32'(bus.sw_out),    32'd0);
        chk("rst_busy", 32'(bus.busy),      32'd0);
        chk("rst_idx",  32'(bus.step_idx),  32'd0);
        chk("rst_sd",   32'(bus.step_done), 32'd0);
        chk("rst_done", 32'(bus.done),      32'd0);
        chk("rst_cap",  32'(bus.cap_led),   32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Manual ownership
        @(negedge clk);
        bus.vio_btn = 5'b10001; bus.vio_sw = 16'hA5A5;
        @(negedge clk);
        chk("manual_btn", 32'(bus.btn_out), 32'h11);
        chk("manual_sw",  32'(bus.sw_out),  32'hA5A5);

        wr_mem(0, 5'h01, 16'h0001, 16'd2);
        wr_mem(1, 5'h02, 16'h0002, 16'd0);
        for (int k = 2; k < DEPTH; k++) wr_mem(k, 5'(k), 16'h1000 + 16'(k), 16'(k % 3));

        // Two-step run with LED capture
        bus.num_steps = 5'd2; bus.loop = 1'b0; bus.start = 1'b1;
        push_run(2, 1, -1);
        @(negedge clk); bus.start = 1'b0; sd0 = sd_cnt; dn0 = dn_cnt;
        @(negedge clk); @(negedge clk); bus.led_in = 16'hBEEF;
        @(negedge clk);
        chk("cap_beef", 32'(bus.cap_led), 32'hBEEF);
        chk("cap_sd",   32'(bus.step_done), 32'd1);
        bus.led_in = '0;
        @(negedge clk);
        chk("run_done", 32'(bus.done), 32'd1);
        chk("run_idle", 32'(bus.busy), 32'd0);
        drain(10);
        chk("run_sd_cnt", 32'(sd_cnt - sd0), 32'd2);
        chk("run_dn_cnt", 32'(dn_cnt - dn0), 32'd1);

        // Step count clamps to DEPTH; start/num_steps while busy ignored
        bus.num_steps = 5'd31; bus.start = 1'b1;
        push_run(DEPTH, 1, -1);
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.num_steps = 5'd1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        drain(60);

        // N=0 start ignored; abort beats start
        bus.num_steps = 5'd0; bus.start = 1'b1;
        @(negedge clk);
        chk("n0_busy", 32'(bus.busy), 32'd0);
        bus.num_steps = 5'd2; bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_start_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);

        // Looping single step, three passes
        wr_mem(0, 5'h1F, 16'h1234, 16'd1);
        bus.num_steps = 5'd1; bus.loop = 1'b1; bus.start = 1'b1;
        push_run(1, 3, -1);
        @(negedge clk); bus.start = 1'b0; dn0 = dn_cnt;
        repeat (4) @(negedge clk);
        bus.loop = 1'b0;
        drain(10);
        chk("loop_dn_cnt", 32'(dn_cnt - dn0), 32'd3);

        // Abort mid step0, with a write attempted while running
        wr_mem(0, 5'h03, 16'h0F0F, 16'd5);
        bus.start = 1'b1;
        push_run(1, 1, 2);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = {5'h1E, 16'hDEAD, 16'd0};
        sd0 = sd_cnt; dn0 = dn_cnt;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("abort_no_pulse", 32'((sd_cnt - sd0) + (dn_cnt - dn0)), 32'd0);
        bus.led_in = 16'h7777; bus.start = 1'b1;
        push_run(1, 1, -1);
        @(negedge clk); bus.start = 1'b0;
        drain(20);
        chk("cap_7777", 32'(bus.cap_led), 32'h7777);

        // Asynchronous reset during a long step
        wr_mem(0, 5'h05, 16'h5555, 16'd100);
        bus.vio_btn = 5'h0A; bus.vio_sw = 16'hC3C3;
        bus.start = 1'b1;
        push_run(1, 1, -1);
        @(negedge clk); bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_btn",  32'(bus.btn_out),  32'd0);
        chk("arst_sw",   32'(bus.sw_out),   32'd0);
        chk("arst_busy", 32'(bus.busy),     32'd0);
        chk("arst_idx",  32'(bus.step_idx), 32'd0);
        chk("arst_cap",  32'(bus.cap_led),  32'd0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("post_rst_btn", 32'(bus.btn_out), 32'h0A);
        chk("post_rst_sw",  32'(bus.sw_out),  32'hC3C3);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
